// File: rtl/dma_pcis_burst_ctrl.sv
// Burst sequencer between the 512-bit DMA PCIS AXI slave and the CNN stream pipeline.
// Queues AW/AR bursts, gates W beats into the pipeline and turns pipeline output into R beats.

module dma_pcis_req_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         nonempty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign nonempty = (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

module dma_pcis_burst_ctrl #(
  parameter int ID_W     = 16,
  parameter int DATA_W   = 512,
  parameter int AQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [7:0]        s_awlen,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [7:0]        s_arlen,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  input  logic [DATA_W-1:0] p_tdata,
  input  logic              p_tvalid,
  output logic              p_tready
);
  localparam int QW = ID_W + 8;

  logic            aw_push, aw_pop, aw_full, aw_nonempty;
  logic [QW-1:0]   aw_head;
  logic            ar_push, ar_pop, ar_full, ar_nonempty;
  logic [QW-1:0]   ar_head;
  logic [ID_W-1:0] aw_head_id, ar_head_id;
  logic [7:0]      aw_head_len, ar_head_len;

  logic [7:0]      wcnt_q, wcnt_d;
  logic            werr_q, werr_d;
  logic            bvalid_q, bvalid_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [7:0]      rcnt_q, rcnt_d;

  logic b_free, w_fire, w_final, r_fire;

  dma_pcis_req_fifo #(.W(QW), .DEPTH(AQ_DEPTH)) u_aw_q (
    .clk       (clk),
    .rst       (rst),
    .push      (aw_push),
    .push_data ({s_awid, s_awlen}),
    .pop       (aw_pop),
    .full      (aw_full),
    .nonempty  (aw_nonempty),
    .head      (aw_head)
  );

  dma_pcis_req_fifo #(.W(QW), .DEPTH(AQ_DEPTH)) u_ar_q (
    .clk       (clk),
    .rst       (rst),
    .push      (ar_push),
    .push_data ({s_arid, s_arlen}),
    .pop       (ar_pop),
    .full      (ar_full),
    .nonempty  (ar_nonempty),
    .head      (ar_head)
  );

  assign aw_head_id  = aw_head[QW-1:8];
  assign aw_head_len = aw_head[7:0];
  assign ar_head_id  = ar_head[QW-1:8];
  assign ar_head_len = ar_head[7:0];

  assign s_awready = !aw_full && !rst;
  assign s_arready = !ar_full && !rst;
  assign aw_push   = s_awvalid && s_awready;
  assign ar_push   = s_arvalid && s_arready;

  // W beats stall whenever a B is stuck, so a final beat can never overwrite a pending B.
  assign b_free   = !bvalid_q || s_bready;
  assign s_wready = aw_nonempty && m_tready && b_free;
  assign m_tvalid = s_wvalid && aw_nonempty && b_free;
  assign m_tdata  = s_wdata;
  assign w_fire   = s_wvalid && s_wready;
  assign w_final  = w_fire && (wcnt_q == aw_head_len);
  assign aw_pop   = w_final;

  assign s_bvalid = bvalid_q;
  assign s_bid    = bid_q;
  assign s_bresp  = bresp_q;

  always_comb begin
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end
    if (w_final) begin
      wcnt_d   = '0;
      werr_d   = 1'b0;
      bvalid_d = 1'b1;
      bid_d    = aw_head_id;
      bresp_d  = (s_wlast && !werr_q) ? 2'b00 : 2'b10;
    end else if (w_fire) begin
      wcnt_d = wcnt_q + 8'd1;
      if (s_wlast) begin
        werr_d = 1'b1;
      end
    end
  end

  // Pipeline output only drains into an open AR burst; stray beats wait.
  assign s_rvalid = ar_nonempty && p_tvalid;
  assign p_tready = ar_nonempty && s_rready;
  assign s_rdata  = p_tdata;
  assign s_rid    = ar_head_id;
  assign s_rresp  = 2'b00;
  assign s_rlast  = (rcnt_q == ar_head_len);
  assign r_fire   = s_rvalid && s_rready;
  assign ar_pop   = r_fire && s_rlast;

  always_comb begin
    rcnt_d = rcnt_q;
    if (r_fire) begin
      rcnt_d = s_rlast ? 8'd0 : rcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      rcnt_q   <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      rcnt_q   <= rcnt_d;
    end
  end
endmodule

// File: tb/tb_dma_pcis_burst_ctrl.sv
// Scoreboard bench for dma_pcis_burst_ctrl: expected m_t beats, B and R responses are queued
// as stimulus is driven and checked by negedge monitors when the DUT produces them.
module tb_dma_pcis_burst_ctrl;
  localparam int ID_W   = 16;
  localparam int DATA_W = 512;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
  } r_exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ID_W-1:0]   s_awid = '0;
  logic [7:0]        s_awlen = '0;
  logic              s_awvalid = 1'b0;
  logic              s_awready;
  logic [DATA_W-1:0] s_wdata = '0;
  logic              s_wlast = 1'b0;
  logic              s_wvalid = 1'b0;
  logic              s_wready;
  logic [ID_W-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready = 1'b1;
  logic [ID_W-1:0]   s_arid = '0;
  logic [7:0]        s_arlen = '0;
  logic              s_arvalid = 1'b0;
  logic              s_arready;
  logic [ID_W-1:0]   s_rid;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              s_rvalid;
  logic              s_rready = 1'b1;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [DATA_W-1:0] p_tdata = '0;
  logic              p_tvalid = 1'b0;
  logic              p_tready;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_m[$];
  b_exp_t            exp_b[$];
  r_exp_t            exp_r[$];
  logic [DATA_W-1:0] exp_rdata[$];

  logic [DATA_W-1:0] m_want, rd_want;
  b_exp_t            b_want;
  r_exp_t            r_want;

  always #5 clk = ~clk;

  dma_pcis_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .p_tdata(p_tdata), .p_tvalid(p_tvalid), .p_tready(p_tready)
  );

  // Inputs change 1 time unit after posedge, so a negedge sample predicts the next handshake.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      checks++;
      if (exp_m.size() == 0) begin
        errors++;
        $display("[TB] FAIL m_beat_unexpected got=%h", m_tdata[63:0]);
      end else begin
        m_want = exp_m.pop_front();
        if (m_tdata !== m_want) begin
          errors++;
          $display("[TB] FAIL m_beat_data got=%h want=%h", m_tdata[63:0], m_want[63:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_bvalid && s_bready) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("[TB] FAIL b_unexpected got id=%h resp=%b", s_bid, s_bresp);
      end else begin
        b_want = exp_b.pop_front();
        if (s_bid !== b_want.id || s_bresp !== b_want.resp) begin
          errors++;
          $display("[TB] FAIL b_resp got id=%h resp=%b want id=%h resp=%b",
                   s_bid, s_bresp, b_want.id, b_want.resp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_rvalid && s_rready) begin
      checks++;
      if (exp_r.size() == 0 || exp_rdata.size() == 0) begin
        errors++;
        $display("[TB] FAIL r_unexpected got id=%h last=%b", s_rid, s_rlast);
      end else begin
        r_want  = exp_r.pop_front();
        rd_want = exp_rdata.pop_front();
        if (s_rid !== r_want.id || s_rlast !== r_want.last || s_rdata !== rd_want
            || s_rresp !== 2'b00) begin
          errors++;
          $display("[TB] FAIL r_beat got id=%h last=%b resp=%b data=%h want id=%h last=%b data=%h",
                   s_rid, s_rlast, s_rresp, s_rdata[63:0], r_want.id, r_want.last, rd_want[63:0]);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_aw(input logic [ID_W-1:0] id, input logic [7:0] len);
    int n = 0;
    s_awid = id; s_awlen = len; s_awvalid = 1'b1;
    @(negedge clk);
    while (!s_awready && n < 200) begin @(negedge clk); n++; end
    if (!s_awready) begin
      checks++; errors++;
      $display("[TB] FAIL aw_timeout got awready=%b want 1", s_awready);
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [7:0] len);
    int n = 0;
    for (int i = 0; i <= int'(len); i++) exp_r.push_back('{id: id, last: (i == int'(len))});
    s_arid = id; s_arlen = len; s_arvalid = 1'b1;
    @(negedge clk);
    while (!s_arready && n < 200) begin @(negedge clk); n++; end
    if (!s_arready) begin
      checks++; errors++;
      $display("[TB] FAIL ar_timeout got arready=%b want 1", s_arready);
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DATA_W-1:0] data, input logic last, output int waited);
    waited = 0;
    exp_m.push_back(data);
    s_wdata = data; s_wlast = last; s_wvalid = 1'b1;
    @(negedge clk);
    while (!s_wready && waited < 200) begin @(negedge clk); waited++; end
    if (!s_wready) begin
      checks++; errors++;
      $display("[TB] FAIL w_timeout got wready=%b want 1", s_wready);
    end
    @(posedge clk); #1;
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic send_p(input logic [DATA_W-1:0] data);
    int n = 0;
    exp_rdata.push_back(data);
    p_tdata = data; p_tvalid = 1'b1;
    @(negedge clk);
    while (!p_tready && n < 200) begin @(negedge clk); n++; end
    if (!p_tready) begin
      checks++; errors++;
      $display("[TB] FAIL p_timeout got p_tready=%b want 1", p_tready);
    end
    @(posedge clk); #1;
    p_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_tvalid, p_tready} !== 7'b0
        || s_bid !== '0 || s_bresp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_outputs got aw=%b ar=%b w=%b b=%b r=%b m=%b p=%b bid=%h bresp=%b want all 0",
               s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_tvalid, p_tready, s_bid, s_bresp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_awready !== 1'b1 || s_arready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got aw=%b ar=%b want 1 1", s_awready, s_arready);
    end
    checks++;
    if (s_wready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wready_no_aw got %b want 0", s_wready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int waited;
    send_aw(16'h0012, 8'd3);
    send_w(rand_data(), 1'b0, waited);
    checks++;
    if (waited != 0) begin
      errors++;
      $display("[TB] FAIL first_beat_latency got %0d extra cycles want 0", waited);
    end
    send_w(rand_data(), 1'b0, waited);
    send_w(rand_data(), 1'b0, waited);
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b_early got bvalid=%b want 0", s_bvalid);
    end
    exp_b.push_back('{id: 16'h0012, resp: 2'b00});
    send_w(rand_data(), 1'b1, waited);
    checks++;
    if (s_bvalid !== 1'b1 || s_bid !== 16'h0012) begin
      errors++;
      $display("[TB] FAIL b_timing got bvalid=%b bid=%h want 1 0012", s_bvalid, s_bid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_early_wlast();
    int waited;
    send_aw(16'h0021, 8'd3);
    exp_b.push_back('{id: 16'h0021, resp: 2'b10});
    send_w(rand_data(), 1'b0, waited);
    send_w(rand_data(), 1'b1, waited);
    send_w(rand_data(), 1'b0, waited);
    send_w(rand_data(), 1'b1, waited);
    send_aw(16'h0022, 8'd1);
    exp_b.push_back('{id: 16'h0022, resp: 2'b00});
    send_w(rand_data(), 1'b0, waited);
    send_w(rand_data(), 1'b1, waited);
    send_aw(16'h0023, 8'd0);
    exp_b.push_back('{id: 16'h0023, resp: 2'b10});
    send_w(rand_data(), 1'b0, waited);
    @(posedge clk); #1;
  endtask

  task automatic test_read_bursts();
    send_ar(16'h0005, 8'd1);
    send_ar(16'h0006, 8'd2);
    for (int i = 0; i < 5; i++) send_p(rand_data());
    p_tdata = rand_data(); p_tvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (p_tready !== 1'b0 || s_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_pipeline got p_tready=%b rvalid=%b want 0 0", p_tready, s_rvalid);
    end
    @(posedge clk); #1;
    p_tvalid = 1'b0;
  endtask

  task automatic test_queue_full();
    int waited;
    for (int i = 0; i < 4; i++) send_aw(ID_W'(16'h0030 + i), 8'd0);
    s_awid = 16'h0034; s_awlen = 8'd0; s_awvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_awready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL awready_full got %b want 0", s_awready);
    end
    @(posedge clk); #1;
    exp_b.push_back('{id: 16'h0030, resp: 2'b00});
    send_w(rand_data(), 1'b1, waited);
    @(negedge clk);
    checks++;
    if (s_awready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL awready_after_pop got %b want 1", s_awready);
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      exp_b.push_back('{id: ID_W'(16'h0030 + i), resp: 2'b00});
      send_w(rand_data(), 1'b1, waited);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int waited;
    logic [DATA_W-1:0] d;
    send_aw(16'h0040, 8'd1);
    send_aw(16'h0041, 8'd0);
    send_w(rand_data(), 1'b0, waited);
    s_bready = 1'b0;
    exp_b.push_back('{id: 16'h0040, resp: 2'b00});
    send_w(rand_data(), 1'b1, waited);
    exp_b.push_back('{id: 16'h0041, resp: 2'b00});
    d = rand_data();
    exp_m.push_back(d);
    s_wdata = d; s_wlast = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_wready !== 1'b0 || m_tvalid !== 1'b0 || s_bvalid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b_stuck_gate got wready=%b m_tvalid=%b bvalid=%b want 0 0 1",
                 s_wready, m_tvalid, s_bvalid);
      end
    end
    @(posedge clk); #1;
    s_bready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_wready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wready_on_bready got %b want 1", s_wready);
    end
    @(posedge clk); #1;
    s_wvalid = 1'b0; s_wlast = 1'b0;
    checks++;
    if (s_bvalid !== 1'b1 || s_bid !== 16'h0041) begin
      errors++;
      $display("[TB] FAIL b_back_to_back got bvalid=%b bid=%h want 1 0041", s_bvalid, s_bid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_backpressure();
    logic [DATA_W-1:0] d0;
    send_ar(16'h0007, 8'd1);
    d0 = rand_data();
    exp_rdata.push_back(d0);
    s_rready = 1'b0; p_tdata = d0; p_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (p_tready !== 1'b0 || s_rvalid !== 1'b1 || s_rdata !== d0 || s_rid !== 16'h0007) begin
        errors++;
        $display("[TB] FAIL r_backpressure got p_tready=%b rvalid=%b rid=%h data=%h want 0 1 0007 %h",
                 p_tready, s_rvalid, s_rid, s_rdata[63:0], d0[63:0]);
      end
    end
    @(posedge clk); #1;
    s_rready = 1'b1;
    @(posedge clk); #1;
    send_p(rand_data());
  endtask

  task automatic test_reset_mid_burst();
    int waited;
    send_aw(16'h0050, 8'd3);
    send_w(rand_data(), 1'b0, waited);
    send_w(rand_data(), 1'b0, waited);
    s_wdata = rand_data(); s_wvalid = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_mtvalid got %b want 1", m_tvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_tvalid, p_tready} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got aw=%b ar=%b w=%b b=%b r=%b m=%b p=%b want all 0",
               s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_tvalid, p_tready);
    end
    s_wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_aw(16'h0051, 8'd0);
    exp_b.push_back('{id: 16'h0051, resp: 2'b00});
    send_w(rand_data(), 1'b1, waited);
    checks++;
    if (s_bvalid !== 1'b1 || s_bid !== 16'h0051 || s_bresp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL b_after_reset got bvalid=%b bid=%h bresp=%b want 1 0051 00",
               s_bvalid, s_bid, s_bresp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drain();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_m.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0 || exp_rdata.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover got m=%0d b=%0d r=%0d rdata=%0d want 0 0 0 0",
               exp_m.size(), exp_b.size(), exp_r.size(), exp_rdata.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_early_wlast();
    test_read_bursts();
    test_queue_full();
    test_back_to_back();
    test_read_backpressure();
    test_reset_mid_burst();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
